button_conditioner: RTL



---
 rtl/button_conditioner_pkg.sv | 21 ++
 rtl/button_conditioner_debounce_cell.sv | 55 +++++
 rtl/button_conditioner.sv | 137 +++++++++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared repeat FSM encoding and default timing constants
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_NUM_BUTTONS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES    = 500000;
  localparam int DEF_TICK_DIV           = 500000;
  localparam int DEF_REPEAT_DELAY_TICKS = 25;
  localparam int DEF_REPEAT_RATE_TICKS  = 5;

  // Counters only ever hold 0..n-1, so clog2(n) bits suffice; never go below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// rtl/button_conditioner_debounce_cell.sv - two-flop synchroniser, debounce counter and press pulse for one key
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic resetN,
  input  logic key_raw,
  output logic stable,
  output logic press_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Any cycle where the synchronised level agrees with stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign stable      = stable_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced keys, slow button clock and per-key auto-repeat strobes
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS        = DEF_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV           = DEF_TICK_DIV,
  parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [NUM_BUTTONS-1:0] keyRaw,
  output logic                   buttonClockOut,
  output logic [NUM_BUTTONS-1:0] buttStable,
  output logic [NUM_BUTTONS-1:0] pressPulse,
  output logic [NUM_BUTTONS-1:0] repeatStrobe
);

  localparam int DW  = cnt_width(TICK_DIV);
  localparam int RCW = (cnt_width(REPEAT_DELAY_TICKS) > cnt_width(REPEAT_RATE_TICKS)) ?
                       cnt_width(REPEAT_DELAY_TICKS) : cnt_width(REPEAT_RATE_TICKS);
  localparam logic [DW-1:0]  DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE_TICKS - 1);

  logic [NUM_BUTTONS-1:0] stable;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clock      (clock),
      .resetN     (resetN),
      .key_raw    (keyRaw[g]),
      .stable     (stable[g]),
      .press_pulse(pressPulse[g])
    );
  end

  logic [DW-1:0]          div_q, div_d;
  logic                   bclk_q, bclk_d;
  logic                   tick;
  logic [NUM_BUTTONS-1:0] butt_stable_q, butt_stable_d;
  logic [NUM_BUTTONS-1:0] strobe_q, strobe_d;
  rpt_state_e             state_q [NUM_BUTTONS];
  rpt_state_e             state_d [NUM_BUTTONS];
  logic [RCW-1:0]         rpt_cnt_q [NUM_BUTTONS];
  logic [RCW-1:0]         rpt_cnt_d [NUM_BUTTONS];

  // tick is the falling edge of buttonClockOut, so everything it updates is settled by the next rise.
  always_comb begin
    div_d  = div_q + 1'b1;
    bclk_d = bclk_q;
    tick   = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      tick   = bclk_q;
    end
    butt_stable_d = tick ? stable : butt_stable_q;
  end

  always_comb begin
    strobe_d = strobe_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (tick) begin
        strobe_d[i] = 1'b1;
        case (state_q[i])
          RPT_IDLE: begin
            if (!stable[i]) begin
              strobe_d[i]  = 1'b0;
              state_d[i]   = RPT_DELAY;
              rpt_cnt_d[i] = '0;
            end
          end
          RPT_DELAY: begin
            if (stable[i]) begin
              state_d[i]   = RPT_IDLE;
              rpt_cnt_d[i] = '0;
            end else if (rpt_cnt_q[i] == DELAY_LAST) begin
              strobe_d[i]  = 1'b0;
              state_d[i]   = RPT_REPEAT;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (stable[i]) begin
              state_d[i]   = RPT_IDLE;
              rpt_cnt_d[i] = '0;
            end else if (rpt_cnt_q[i] == RATE_LAST) begin
              strobe_d[i]  = 1'b0;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i]   = RPT_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      div_q         <= '0;
      bclk_q        <= 1'b0;
      butt_stable_q <= '1;
      strobe_q      <= '1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i]   <= RPT_IDLE;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      butt_stable_q <= butt_stable_d;
      strobe_q      <= strobe_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i]   <= state_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign buttonClockOut = bclk_q;
  assign buttStable     = butt_stable_q;
  assign repeatStrobe   = strobe_q;

endmodule
